// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter and its scoreboard.
package regfile_wb_arbiter_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NUM_REGS  = 32;

  typedef enum logic [0:0] {
    A_PRIO,
    B_FORCE
  } arb_state_e;

  function automatic logic [NUM_REGS-1:0] idx_onehot(input logic [REG_IDX_W-1:0] idx);
    idx_onehot = NUM_REGS'(1) << idx;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, x0 never pending.
module regfile_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_set,
  input  logic [REG_IDX_W-1:0] i_set_idx,
  input  logic                 i_clr,
  input  logic [REG_IDX_W-1:0] i_clr_idx,
  input  logic [REG_IDX_W-1:0] i_lkp0_idx,
  input  logic [REG_IDX_W-1:0] i_lkp1_idx,
  input  logic [REG_IDX_W-1:0] i_lkp2_idx,
  output logic [NUM_REGS-1:0]  o_pending,
  output logic                 o_lkp0_hit,
  output logic                 o_lkp1_hit,
  output logic                 o_lkp2_hit
);

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic [NUM_REGS-1:0] w_pending_d;

  assign w_set_mask = (i_set && (i_set_idx != '0)) ? idx_onehot(i_set_idx) : '0;
  assign w_clr_mask = i_clr ? idx_onehot(i_clr_idx) : '0;

  // Set is applied after clear so a same-index collision leaves the register pending.
  assign w_pending_d = ((r_pending & ~w_clr_mask) | w_set_mask) & ~NUM_REGS'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_d;
    end
  end

  assign o_pending  = r_pending;
  assign o_lkp0_hit = r_pending[i_lkp0_idx];
  assign o_lkp1_hit = r_pending[i_lkp1_idx];
  assign o_lkp2_hit = r_pending[i_lkp2_idx];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the pipeline (A) and a
// long-latency unit (B), with starvation protection for B and a pending-register scoreboard.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned XLEN         = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [REG_IDX_W-1:0] a_rd,
  input  logic [XLEN-1:0]      a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [REG_IDX_W-1:0] b_rd,
  input  logic [XLEN-1:0]      b_data,
  input  logic                 sb_set,
  input  logic [REG_IDX_W-1:0] sb_set_rd,
  input  logic [REG_IDX_W-1:0] chk_rs1,
  input  logic [REG_IDX_W-1:0] chk_rs2,
  input  logic [REG_IDX_W-1:0] chk_rd,
  output logic                 hazard,
  output logic                 wb_en,
  output logic [REG_IDX_W-1:0] rd_index,
  output logic [XLEN-1:0]      wb_data,
  output logic                 pipe_stall,
  output logic [NUM_REGS-1:0]  pending
);

  localparam int unsigned       CntW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0]   CntMax  = CntW'(STARVE_LIMIT);
  localparam logic [CntW-1:0]   CntTrip = CntW'(STARVE_LIMIT - 1);

  arb_state_e          r_state;
  logic [CntW-1:0]     r_starve_cnt;
  logic                r_wb_en;
  logic [REG_IDX_W-1:0] r_rd_index;
  logic [XLEN-1:0]     r_wb_data;

  logic w_a_ready;
  logic w_b_ready;
  logic w_a_acc;
  logic w_b_acc;
  logic w_b_wait;
  logic w_b_fwd;
  logic w_hit_rs1;
  logic w_hit_rs2;
  logic w_hit_rd;

  assign w_a_ready = (r_state == A_PRIO);
  assign w_b_ready = (r_state == B_FORCE) || !a_valid;
  assign w_a_acc   = a_valid && w_a_ready;
  assign w_b_acc   = b_valid && w_b_ready;
  assign w_b_wait  = (r_state == A_PRIO) && a_valid && b_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= A_PRIO;
      r_starve_cnt <= '0;
    end else begin
      unique case (r_state)
        A_PRIO: begin
          if (w_b_acc) begin
            r_starve_cnt <= '0;
          end else if (w_b_wait) begin
            if (r_starve_cnt != CntMax) begin
              r_starve_cnt <= r_starve_cnt + CntW'(1);
            end
            if (r_starve_cnt == CntTrip) begin
              r_state <= B_FORCE;
            end
          end
        end
        B_FORCE: begin
          // B has the port for exactly one cycle: taken, or withdrawn.
          if (w_b_acc || !b_valid) begin
            r_state      <= A_PRIO;
            r_starve_cnt <= '0;
          end
        end
        default: begin
          r_state      <= A_PRIO;
          r_starve_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_en    <= 1'b0;
      r_rd_index <= '0;
      r_wb_data  <= '0;
    end else if (w_a_acc) begin
      r_wb_en    <= (a_rd != '0);
      r_rd_index <= a_rd;
      r_wb_data  <= a_data;
    end else if (w_b_acc) begin
      r_wb_en    <= (b_rd != '0);
      r_rd_index <= b_rd;
      r_wb_data  <= b_data;
    end else begin
      r_wb_en    <= 1'b0;
    end
  end

  regfile_scoreboard u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set      (sb_set),
    .i_set_idx  (sb_set_rd),
    .i_clr      (w_b_acc),
    .i_clr_idx  (b_rd),
    .i_lkp0_idx (chk_rs1),
    .i_lkp1_idx (chk_rs2),
    .i_lkp2_idx (chk_rd),
    .o_pending  (pending),
    .o_lkp0_hit (w_hit_rs1),
    .o_lkp1_hit (w_hit_rs2),
    .o_lkp2_hit (w_hit_rd)
  );

  // A B result accepted this cycle is not in the register file until next cycle.
  assign w_b_fwd = w_b_acc && (b_rd != '0) &&
                   ((b_rd == chk_rs1) || (b_rd == chk_rs2) || (b_rd == chk_rd));

  assign hazard     = w_hit_rs1 | w_hit_rs2 | w_hit_rd | w_b_fwd;
  assign a_ready    = w_a_ready;
  assign b_ready    = w_b_ready;
  assign pipe_stall = !w_a_ready;
  assign wb_en      = r_wb_en;
  assign rd_index   = r_rd_index;
  assign wb_data    = r_wb_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_rd, b_rd, sb_set_rd, chk_rs1, chk_rs2, chk_rd, rd_index;
  logic [31:0] a_data, b_data, wb_data, pending;
  logic        sb_set, hazard, wb_en, pipe_stall;

  regfile_wb_arbiter #(
    .STARVE_LIMIT (LIMIT),
    .XLEN         (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_rd       (a_rd),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_rd       (b_rd),
    .b_data     (b_data),
    .sb_set     (sb_set),
    .sb_set_rd  (sb_set_rd),
    .chk_rs1    (chk_rs1),
    .chk_rs2    (chk_rs2),
    .chk_rd     (chk_rd),
    .hazard     (hazard),
    .wb_en      (wb_en),
    .rd_index   (rd_index),
    .wb_data    (wb_data),
    .pipe_stall (pipe_stall),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: how many cycles B has been refused; B owns the port once this reaches LIMIT.
  int unsigned m_streak;
  bit [31:0]   m_pend;
  bit          m_wb_en;
  bit [4:0]    m_rd;
  bit [31:0]   m_data;
  bit          e_a_ready, e_b_ready, e_hazard, m_a_acc, m_b_acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_streak = 0;
    m_pend   = '0;
    m_wb_en  = 1'b0;
    m_rd     = '0;
    m_data   = '0;
    m_a_acc  = 1'b0;
    m_b_acc  = 1'b0;
  endtask

  task automatic clear_inputs();
    a_valid = 0; a_rd = 0; a_data = 0;
    b_valid = 0; b_rd = 0; b_data = 0;
    sb_set = 0; sb_set_rd = 0;
    chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
  endtask

  // Let combinational outputs settle, then compare everything against the model.
  task automatic settle();
    bit fwd;
    #1;
    e_a_ready = (m_streak != LIMIT);
    e_b_ready = (m_streak == LIMIT) || !a_valid;
    m_a_acc   = a_valid && e_a_ready;
    m_b_acc   = b_valid && e_b_ready;
    fwd = m_b_acc && (b_rd != 0) && (b_rd == chk_rs1 || b_rd == chk_rs2 || b_rd == chk_rd);
    e_hazard = m_pend[chk_rs1] | m_pend[chk_rs2] | m_pend[chk_rd] | fwd;
    check("a_ready", 64'(a_ready), 64'(e_a_ready));
    check("b_ready", 64'(b_ready), 64'(e_b_ready));
    check("pipe_stall", 64'(pipe_stall), 64'(!e_a_ready));
    check("hazard", 64'(hazard), 64'(e_hazard));
    check("wb_en", 64'(wb_en), 64'(m_wb_en));
    if (m_wb_en) begin
      check("rd_index", 64'(rd_index), 64'(m_rd));
      check("wb_data", 64'(wb_data), 64'(m_data));
    end
    check("pending", 64'(pending), 64'(m_pend));
  endtask

  // Apply this cycle's accepted transfers to the model, then move to the next cycle.
  task automatic advance();
    if (m_a_acc) begin
      m_wb_en = (a_rd != 0); m_rd = a_rd; m_data = a_data;
    end else if (m_b_acc) begin
      m_wb_en = (b_rd != 0); m_rd = b_rd; m_data = b_data;
    end else begin
      m_wb_en = 1'b0;
    end
    if (m_b_acc) m_pend[b_rd] = 1'b0;
    if (sb_set && sb_set_rd != 0) m_pend[sb_set_rd] = 1'b1;
    m_pend[0] = 1'b0;
    if (m_b_acc || m_streak == LIMIT) m_streak = 0;
    else if (a_valid && b_valid && m_streak < LIMIT) m_streak++;
    @(negedge clk);
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    clear_inputs();
    #1;
    model_reset();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_wb_en"}, 64'(wb_en), 64'd0);
    check({tag, "_rd_index"}, 64'(rd_index), 64'd0);
    check({tag, "_wb_data"}, 64'(wb_data), 64'd0);
    check({tag, "_pending"}, 64'(pending), 64'd0);
    check({tag, "_a_ready"}, 64'(a_ready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    assert_reset();
    check_reset_state("reset");
    release_reset();

    // Single pipeline write lands one cycle after acceptance.
    a_valid = 1; a_rd = 5; a_data = 32'hDEAD_BEEF;
    settle();
    check("req037_a_ready_c0", 64'(a_ready), 64'd1);
    advance();
    a_valid = 0;
    settle();
    check("req037_wb_en", 64'(wb_en), 64'd1);
    check("req037_rd_index", 64'(rd_index), 64'd5);
    check("req037_wb_data", 64'(wb_data), 64'hDEAD_BEEF);
    check("req037_a_ready_c1", 64'(a_ready), 64'd1);
    advance();

    // Starvation: B refused four cycles, then forced through.
    assert_reset(); release_reset();
    b_valid = 1; b_rd = 7; b_data = 32'h0000_0077;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1; a_rd = 5'(10 + i); a_data = 32'hA000_0000 + 32'(i);
      settle();
      check("req038_b_ready_wait", 64'(b_ready), 64'd0);
      advance();
    end
    a_rd = 5'd14; a_data = 32'hA000_0004;
    settle();
    check("req038_a_ready_force", 64'(a_ready), 64'd0);
    check("req038_b_ready_force", 64'(b_ready), 64'd1);
    advance();
    b_valid = 0;
    settle();
    check("req038_wb_en", 64'(wb_en), 64'd1);
    check("req038_rd_index", 64'(rd_index), 64'd7);
    check("req038_wb_data", 64'(wb_data), 64'h77);
    check("req038_a_ready", 64'(a_ready), 64'd1);
    advance();

    // Scoreboard hazard lifetime.
    assert_reset(); release_reset();
    sb_set = 1; sb_set_rd = 9;
    settle(); advance();
    sb_set = 0; chk_rs1 = 9;
    settle();
    check("req039_hazard_pending", 64'(hazard), 64'd1);
    advance();
    b_valid = 1; b_rd = 9; b_data = 32'h99;
    settle();
    check("req039_hazard_accept", 64'(hazard), 64'd1);
    advance();
    b_valid = 0;
    settle();
    check("req039_hazard_after", 64'(hazard), 64'd0);
    advance();

    // Set and clear of the same index in one cycle: set wins.
    assert_reset(); release_reset();
    sb_set = 1; sb_set_rd = 3; b_valid = 1; b_rd = 3; b_data = 32'h33;
    settle(); advance();
    sb_set = 0; b_valid = 0; chk_rs2 = 3;
    settle();
    check("req040_pending3", 64'(pending[3]), 64'd1);
    check("req040_hazard", 64'(hazard), 64'd1);
    advance();

    // x0 is never written and never pending.
    assert_reset(); release_reset();
    a_valid = 1; a_rd = 0; a_data = 32'h1234;
    settle(); advance();
    a_valid = 0; sb_set = 1; sb_set_rd = 0;
    settle();
    check("req041_wb_en", 64'(wb_en), 64'd0);
    advance();
    sb_set = 0; chk_rd = 0;
    settle();
    check("req041_hazard", 64'(hazard), 64'd0);
    check("req041_pending", 64'(pending), 64'd0);
    advance();

    // Reset while B is forced with three registers pending.
    assert_reset(); release_reset();
    b_valid = 1; b_rd = 8; b_data = 32'h88;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1; a_rd = 5'(10 + i); a_data = 32'(i);
      sb_set = (i < 3); sb_set_rd = 5'(4 + i);
      settle(); advance();
    end
    sb_set = 0;
    settle();
    check("req042_a_ready_force", 64'(a_ready), 64'd0);
    check("req042_pending_before", 64'(pending), 64'h70);
    check("req042_wb_en_before", 64'(wb_en), 64'd1);
    assert_reset();
    check_reset_state("req042_async");
    release_reset();
    a_valid = 1; a_rd = 2; a_data = 32'h22;
    settle();
    check("req042_a_ready_release", 64'(a_ready), 64'd1);
    advance();

    // Randomized traffic; requesters hold rd/data until accepted.
    assert_reset(); release_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (m_a_acc) a_valid = 0;
      if (m_b_acc) b_valid = 0;
      if (b_valid && $urandom_range(0, 99) < 4) b_valid = 0;
      if (!a_valid && $urandom_range(0, 99) < 80) begin
        a_valid = 1; a_rd = 5'($urandom_range(0, 7)); a_data = $urandom;
      end
      if (!b_valid && $urandom_range(0, 99) < 50) begin
        b_valid = 1; b_rd = 5'($urandom_range(0, 7)); b_data = $urandom;
      end
      sb_set    = ($urandom_range(0, 99) < 30);
      sb_set_rd = 5'($urandom_range(0, 7));
      chk_rs1   = 5'($urandom_range(0, 7));
      chk_rs2   = 5'($urandom_range(0, 7));
      chk_rd    = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 999) == 0) begin
        assert_reset();
        check_reset_state("rand_reset");
        release_reset();
      end else begin
        settle();
        advance();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
